// File: rtl/uart_dev_pkg.sv
// uart_dev_pkg: register offsets, STATUS/CTRL bit positions, shared FSM
// state encoding and divisor helpers for the uart_dev peripheral.
package uart_dev_pkg;

  // Byte offsets of the four registers; only Addr[3:2] is decoded
  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_DIV    = 8'h0C;

  localparam logic [1:0] IDX_DATA   = OFF_DATA[3:2];
  localparam logic [1:0] IDX_STATUS = OFF_STATUS[3:2];
  localparam logic [1:0] IDX_CTRL   = OFF_CTRL[3:2];
  localparam logic [1:0] IDX_DIV    = OFF_DIV[3:2];

  // STATUS bit positions
  localparam int unsigned ST_RX_VALID   = 32'd0;
  localparam int unsigned ST_TX_BUSY    = 32'd1;
  localparam int unsigned ST_RX_OVERRUN = 32'd2;
  localparam int unsigned ST_TX_DONE    = 32'd3;
  localparam int unsigned ST_FRAME_ERR  = 32'd4;

  // CTRL bit positions
  localparam int unsigned CTRL_RX_IRQ_EN = 32'd0;
  localparam int unsigned CTRL_TX_IRQ_EN = 32'd1;
  localparam int unsigned CTRL_LOOPBACK  = 32'd2;

  // Smallest divisor that still gives a non-zero half-bit wait
  localparam logic [15:0] MIN_DIV = 16'd2;

  // Frame phases shared by the transmitter and the receiver
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  typedef uart_state_e tx_state_e;
  typedef uart_state_e rx_state_e;

  // Raise divisor writes below the minimum to the minimum
  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_dev_rx.sv
// uart_dev_rx: 8N1 receiver. Two-flop synchronizer, start-bit glitch
// filter at half a bit, mid-bit sampling LSB first. done_o / ferr_o are
// single-cycle strobes valid in the cycle the stop bit is sampled.
module uart_dev_rx
  import uart_dev_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd_i,
  input  logic [15:0] div_i,
  output logic [7:0]  byte_o,
  output logic        done_o,
  output logic        ferr_o
);

  logic        sync1_q, sync2_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        half_end_s, bit_end_s;

  assign half_end_s = (cnt_q == ((div_q >> 1) - 16'd1));
  assign bit_end_s  = (cnt_q == (div_q - 16'd1));
  assign byte_o     = shift_q;

  // Bring the asynchronous serial line into the clk domain (idle high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
    end
  end

  // Receiver state, baud counter, latched divisor and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      div_q   <= MIN_DIV;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: detect start, filter glitches, sample bits and stop
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_o  = 1'b0;
    ferr_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_START;
          cnt_d   = 16'd0;
          div_d   = div_i;
        end else begin
          cnt_d   = 16'd0;
        end
      end
      S_START: begin
        if (half_end_s) begin
          cnt_d = 16'd0;
          bit_d = 3'd0;
          if (sync2_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d   = 16'd0;
          state_d = S_IDLE;
          if (sync2_q) begin
            done_o = 1'b1;
          end else begin
            ferr_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

endmodule

// File: rtl/uart_dev.sv
// uart_dev: SouthBridge Dev1 UART. Register file (DATA/STATUS/CTRL/DIV),
// 8N1 transmitter and level interrupt; the receiver is uart_dev_rx.
// Optional feature macro: UART_DEV_LOOPBACK_EN (CTRL bit2 internal loopback).
module uart_dev
  import uart_dev_pkg::*;
#(
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic [7:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  // Register file state
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_done_q, tx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_irq_en_q, rx_irq_en_d;
  logic        tx_irq_en_q, tx_irq_en_d;
  logic        loopback_q, loopback_d;
  logic [15:0] div_q, div_d;

  // Transmitter state
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;

  logic        wr_data_s, wr_status_s, wr_ctrl_s, wr_div_s;
  logic        tx_busy_s, tx_bit_end_s, tx_finish_s;
  logic        rx_line_s, rx_done_s, rx_ferr_s, rx_load_s;
  logic [7:0]  rx_data_s;
  logic        unused_s;

  assign wr_data_s    = WE && (Addr[3:2] == IDX_DATA);
  assign wr_status_s  = WE && (Addr[3:2] == IDX_STATUS);
  assign wr_ctrl_s    = WE && (Addr[3:2] == IDX_CTRL);
  assign wr_div_s     = WE && (Addr[3:2] == IDX_DIV);
  assign unused_s     = ^{Addr[7:4], Addr[1:0], Din[31:16]};

  assign tx_busy_s    = (tx_state_q != S_IDLE);
  assign tx_bit_end_s = (tx_cnt_q == (tx_div_q - 16'd1));

`ifdef UART_DEV_LOOPBACK_EN
  assign rx_line_s = loopback_q ? txd_q : uart_rxd;
  assign uart_txd  = loopback_q ? 1'b1 : txd_q;
`else
  assign rx_line_s = uart_rxd;
  assign uart_txd  = txd_q;
`endif

  uart_dev_rx u_rx (
    .clk    (clk),
    .rst_n  (sys_rstn),
    .rxd_i  (rx_line_s),
    .div_i  (div_q),
    .byte_o (rx_data_s),
    .done_o (rx_done_s),
    .ferr_o (rx_ferr_s)
  );

  // Status bits: write-1-to-clear, with a same-cycle hardware set winning
  assign rx_load_s    = rx_done_s && !rx_valid_q;
  assign rx_valid_d   = rx_load_s | (rx_valid_q & ~(wr_status_s & Din[ST_RX_VALID]));
  assign rx_overrun_d = (rx_done_s & rx_valid_q)
                      | (rx_overrun_q & ~(wr_status_s & Din[ST_RX_OVERRUN]));
  assign tx_done_d    = tx_finish_s | (tx_done_q & ~(wr_status_s & Din[ST_TX_DONE]));
  assign frame_err_d  = rx_ferr_s | (frame_err_q & ~(wr_status_s & Din[ST_FRAME_ERR]));
  assign rx_byte_d    = rx_load_s ? rx_data_s : rx_byte_q;

  assign IRQ = (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & tx_done_q);

  // CTRL and DIV software writes
  always_comb begin
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    loopback_d  = loopback_q;
    div_d       = div_q;
    if (wr_ctrl_s) begin
      rx_irq_en_d = Din[CTRL_RX_IRQ_EN];
      tx_irq_en_d = Din[CTRL_TX_IRQ_EN];
`ifdef UART_DEV_LOOPBACK_EN
      loopback_d  = Din[CTRL_LOOPBACK];
`endif
    end else begin
      rx_irq_en_d = rx_irq_en_q;
    end
    if (wr_div_s) begin
      div_d = clamp_div(Din[15:0]);
    end else begin
      div_d = div_q;
    end
  end

  // Register file flops
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_byte_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_irq_en_q  <= 1'b0;
      tx_irq_en_q  <= 1'b0;
      loopback_q   <= 1'b0;
      div_q        <= DEFAULT_DIV;
    end else begin
      rx_byte_q    <= rx_byte_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_done_q    <= tx_done_d;
      frame_err_q  <= frame_err_d;
      rx_irq_en_q  <= rx_irq_en_d;
      tx_irq_en_q  <= tx_irq_en_d;
      loopback_q   <= loopback_d;
      div_q        <= div_d;
    end
  end

  // Transmitter next state; a DATA write landing as the stop bit ends starts
  // the next frame back to back
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    tx_finish_s = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (wr_data_s) begin
          tx_state_d = S_START;
          tx_cnt_d   = 16'd0;
          tx_div_d   = div_q;
          tx_shift_d = Din[7:0];
          txd_d      = 1'b0;
        end else begin
          txd_d      = 1'b1;
        end
      end
      S_START: begin
        if (tx_bit_end_s) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = 16'd0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d   = tx_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_bit_end_s) begin
          tx_cnt_d   = 16'd0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d   = tx_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_bit_end_s) begin
          tx_finish_s = 1'b1;
          tx_cnt_d    = 16'd0;
          if (wr_data_s) begin
            tx_state_d = S_START;
            tx_div_d   = div_q;
            tx_shift_d = Din[7:0];
            txd_d      = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
            txd_d      = 1'b1;
          end
        end else begin
          tx_cnt_d    = tx_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_cnt_d   = 16'd0;
        txd_d      = 1'b1;
      end
    endcase
  end

  // Transmitter flops; the serial output is registered and idles high
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= MIN_DIV;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Read mux: combinational from Addr[3:2] and register state
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      IDX_DATA:   Dout = {24'd0, rx_byte_q};
      IDX_STATUS: Dout = {27'd0, frame_err_q, tx_done_q, rx_overrun_q,
                          tx_busy_s, rx_valid_q};
      IDX_CTRL:   Dout = {29'd0, loopback_q, tx_irq_en_q, rx_irq_en_q};
      IDX_DIV:    Dout = {16'd0, div_q};
      default:    Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: scoreboard bench for uart_dev. Stimulus pushes expected
// register/IRQ/txd values and expected TX bytes into queues; two monitor
// processes pop and compare when a read is presented or a TX frame starts.
module tb_uart_dev;

  localparam int K_REG = 0;
  localparam int K_IRQ = 1;
  localparam int K_TXD = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk;
  logic        sys_rstn;
  logic [7:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        uart_rxd;
  logic        uart_txd;

  int n_tests;
  int n_fail;

  chk_t        chk_q[$];
  logic [7:0]  tx_q[$];
  logic        chk_req;

  chk_t        cur;
  logic [31:0] got;

  logic        tx_active;
  logic        tx_unexp;
  logic        tx_bad;
  int          tx_cyc;
  logic [9:0]  tx_frame;
  logic [9:0]  tx_got;
  logic [7:0]  tx_byte;

  uart_dev #(.DEFAULT_DIV(16'd434)) dut (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .Addr     (Addr),
    .WE       (WE),
    .Din      (Din),
    .Dout     (Dout),
    .IRQ      (IRQ),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register/IRQ/txd monitor
  always @(negedge clk) begin
    if (chk_req) begin
      n_tests = n_tests + 1;
      if (chk_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL scoreboard_empty: read presented with no expectation queued");
      end else begin
        cur = chk_q.pop_front();
        case (cur.kind)
          K_IRQ:   got = {31'd0, IRQ};
          K_TXD:   got = {31'd0, uart_txd};
          default: got = Dout;
        endcase
        if (got !== cur.exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, got, cur.exp);
        end
      end
    end
  end

  // TX frame monitor: 10 bits x 4 clocks, every clock compared
  always @(negedge clk) begin
    if (!sys_rstn) begin
      tx_active = 1'b0;
    end else begin
      if (!tx_active && uart_txd === 1'b0) begin
        tx_active = 1'b1;
        tx_cyc    = 0;
        tx_bad    = 1'b0;
        tx_got    = 10'd0;
        if (tx_q.size() == 0) begin
          tx_unexp = 1'b1;
          tx_frame = 10'd0;
          n_tests  = n_tests + 1;
          n_fail   = n_fail + 1;
          $display("FAIL tx_unexpected_frame: start bit seen with no frame expected");
        end else begin
          tx_unexp = 1'b0;
          tx_byte  = tx_q.pop_front();
          tx_frame = {1'b1, tx_byte, 1'b0};
        end
      end
      if (tx_active) begin
        if (uart_txd !== tx_frame[tx_cyc / 4]) tx_bad = 1'b1;
        if ((tx_cyc % 4) == 2) tx_got[tx_cyc / 4] = uart_txd;
        tx_cyc = tx_cyc + 1;
        if (tx_cyc == 40) begin
          tx_active = 1'b0;
          if (!tx_unexp) begin
            n_tests = n_tests + 1;
            if (tx_bad) begin
              n_fail = n_fail + 1;
              $display("FAIL tx_frame: got bits 0x%03h expected 0x%03h (or bit width not 4)",
                       tx_got, tx_frame);
            end
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  task automatic chk(input int kind, input logic [7:0] a, input logic [31:0] e,
                     input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = e;
    c.name = name;
    Addr   = a;
    chk_q.push_back(c);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  // Drive one 8N1 frame at 4 clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rxd = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    uart_rxd = 1'b1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    chk_req   = 1'b0;
    tx_active = 1'b0;
    tx_unexp  = 1'b0;
    tx_cyc    = 0;
    sys_rstn  = 1'b0;
    uart_rxd  = 1'b1;
    WE        = 1'b0;
    Addr      = 8'h00;
    Din       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    sys_rstn = 1'b1;

    // Reset state
    chk(K_REG, 8'h00, 32'h0000_0000, "reset_data");
    chk(K_REG, 8'h04, 32'h0000_0000, "reset_status");
    chk(K_REG, 8'h08, 32'h0000_0000, "reset_ctrl");
    chk(K_REG, 8'h0C, 32'h0000_01B2, "reset_div");
    chk(K_IRQ, 8'h00, 32'd0, "reset_irq");
    chk(K_TXD, 8'h00, 32'd1, "reset_txd");
    // Ignored address bits
    chk(K_REG, 8'hF4, 32'h0000_0000, "alias_status");
    chk(K_REG, 8'h0D, 32'h0000_01B2, "alias_div");

    // Divisor clamp
    wr(8'h0C, 32'd1);
    chk(K_REG, 8'h0C, 32'd2, "div_clamp_1");
    wr(8'h0C, 32'hFFFF_0000);
    chk(K_REG, 8'h0C, 32'd2, "div_clamp_0");
    wr(8'h0C, 32'd4);
    chk(K_REG, 8'h0C, 32'd4, "div_4");

    // TX 0x5A, a write while busy is dropped
    tx_q.push_back(8'h5A);
    wr(8'h00, 32'h0000_005A);
    wr(8'h00, 32'h0000_0011);
    repeat (38) @(posedge clk);
    #1;
    chk(K_REG, 8'h04, 32'h0000_0002, "tx_busy_cycle39");
    chk(K_REG, 8'h04, 32'h0000_0008, "tx_done_cycle40");
    wr(8'h08, 32'h0000_0002);
    chk(K_IRQ, 8'h00, 32'd1, "tx_irq_set");
    wr(8'h04, 32'h0000_0008);
    chk(K_IRQ, 8'h00, 32'd0, "tx_irq_clear");
    chk(K_REG, 8'h04, 32'h0000_0000, "tx_done_w1c");
    wr(8'h08, 32'h0000_0000);

    // RX 0xA5 and interrupt
    send_rx(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk(K_REG, 8'h04, 32'h0000_0001, "rx_valid");
    chk(K_REG, 8'h00, 32'h0000_00A5, "rx_data_a5");
    chk(K_IRQ, 8'h00, 32'd0, "rx_irq_disabled");
    wr(8'h08, 32'h0000_0001);
    chk(K_IRQ, 8'h00, 32'd1, "rx_irq_set");
    wr(8'h04, 32'h0000_0001);
    chk(K_IRQ, 8'h00, 32'd0, "rx_irq_clear");
    chk(K_REG, 8'h04, 32'h0000_0000, "rx_valid_w1c");
    wr(8'h08, 32'h0000_0000);

    // Overrun: second byte dropped
    send_rx(8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send_rx(8'h02, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk(K_REG, 8'h00, 32'h0000_0001, "overrun_data_kept");
    chk(K_REG, 8'h04, 32'h0000_0005, "overrun_status");
    wr(8'h04, 32'h0000_001F);
    chk(K_REG, 8'h04, 32'h0000_0000, "overrun_w1c");

    // Framing error, then a one-cycle glitch
    send_rx(8'h55, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk(K_REG, 8'h04, 32'h0000_0010, "frame_err");
    chk(K_REG, 8'h00, 32'h0000_0001, "frame_err_data_kept");
    wr(8'h04, 32'h0000_0010);
    uart_rxd = 1'b0;
    @(posedge clk);
    #1;
    uart_rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk(K_REG, 8'h04, 32'h0000_0000, "glitch_no_status");

`ifdef UART_DEV_LOOPBACK_EN
    wr(8'h08, 32'h0000_0004);
    chk(K_REG, 8'h08, 32'h0000_0004, "ctrl_loopback");
    wr(8'h00, 32'h0000_003C);
    chk(K_TXD, 8'h00, 32'd1, "loop_txd_high_a");
    chk(K_TXD, 8'h00, 32'd1, "loop_txd_high_b");
    repeat (20) @(posedge clk);
    #1;
    chk(K_TXD, 8'h00, 32'd1, "loop_txd_high_c");
    repeat (28) @(posedge clk);
    #1;
    chk(K_REG, 8'h04, 32'h0000_0009, "loop_status");
    chk(K_REG, 8'h00, 32'h0000_003C, "loop_data");
    wr(8'h08, 32'h0000_0000);
    wr(8'h04, 32'h0000_001F);
`else
    wr(8'h08, 32'h0000_0007);
    chk(K_REG, 8'h08, 32'h0000_0003, "ctrl_no_loopback");
    wr(8'h08, 32'h0000_0000);
`endif

    // Reset mid-frame aborts TX
    tx_q.push_back(8'h0F);
    wr(8'h00, 32'h0000_000F);
    repeat (10) @(posedge clk);
    #1;
    sys_rstn = 1'b0;
    #1;
    chk(K_TXD, 8'h00, 32'd1, "reset_abort_txd");
    sys_rstn = 1'b1;
    chk(K_REG, 8'h0C, 32'h0000_01B2, "reset_again_div");
    chk(K_REG, 8'h04, 32'h0000_0000, "reset_again_status");
    chk(K_REG, 8'h00, 32'h0000_0000, "reset_again_data");
    repeat (5) @(posedge clk);
    #1;

    n_tests = n_tests + 1;
    if (tx_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL tx_frames_pending: got %0d frames left expected 0", tx_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
